// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: default widths, pipeline-register state
// encoding and the decoded-instruction payload.
package cpu_pkg;

    localparam int unsigned CPU_XLEN    = 32;
    localparam int unsigned CPU_OPC_W   = 6;
    localparam int unsigned CPU_REG_W   = 5;
    localparam int unsigned CPU_IMMJ_W  = CPU_XLEN - CPU_OPC_W;
    localparam int unsigned CPU_IMMAB_W = CPU_XLEN - CPU_OPC_W - 2 * CPU_REG_W;

    // Occupancy of the main + skid storage.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    // Decoded fields plus PC at the default configuration.
    typedef struct packed {
        logic [CPU_XLEN-1:0]    pc;
        logic [CPU_OPC_W-1:0]   opc;
        logic [CPU_REG_W-1:0]   rs1;
        logic [CPU_REG_W-1:0]   rs2_rd;
        logic [CPU_REG_W-1:0]   rd;
        logic [CPU_IMMJ_W-1:0]  imm_j;
        logic [CPU_IMMAB_W-1:0] imm_ab;
    } dec_t;

endpackage

// File: rtl/instr_field_split.sv
// Opcode-agnostic split of an instruction word into its fields, plus the
// extended ALU/branch immediate.
module instr_field_split
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN     = CPU_XLEN,
    parameter int unsigned OPC_W    = CPU_OPC_W,
    parameter int unsigned REG_W    = CPU_REG_W,
    parameter bit          IMM_SEXT = 1'b1,
    parameter type         dec_t    = cpu_pkg::dec_t
) (
    input  logic [XLEN-1:0] word_i,
    input  logic [XLEN-1:0] pc_i,
    output dec_t            dec_o,
    output logic [XLEN-1:0] imm_ext_o
);

    localparam int unsigned IMMJ_W  = XLEN - OPC_W;
    localparam int unsigned IMMAB_W = XLEN - OPC_W - 2 * REG_W;
    localparam int unsigned EXT_W   = XLEN - IMMAB_W;

    always_comb begin
        dec_o        = '0;
        dec_o.pc     = pc_i;
        dec_o.opc    = word_i[XLEN-1 -: OPC_W];
        dec_o.rs1    = word_i[XLEN-OPC_W-1 -: REG_W];
        dec_o.rs2_rd = word_i[XLEN-OPC_W-REG_W-1 -: REG_W];
        dec_o.rd     = word_i[IMMAB_W-1 -: REG_W];
        dec_o.imm_j  = word_i[IMMJ_W-1:0];
        dec_o.imm_ab = word_i[IMMAB_W-1:0];
    end

    if (IMM_SEXT) begin : g_sext
        assign imm_ext_o = {{EXT_W{word_i[IMMAB_W-1]}}, word_i[IMMAB_W-1:0]};
    end else begin : g_zext
        assign imm_ext_o = {{EXT_W{1'b0}}, word_i[IMMAB_W-1:0]};
    end

endmodule

// File: rtl/instr_decode_reg.sv
// Fetch-to-decode pipeline register: valid/ready capture with a 2-entry skid
// buffer, registered field split and flush for taken branches/jumps.
module instr_decode_reg
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN     = CPU_XLEN,
    parameter int unsigned OPC_W    = CPU_OPC_W,
    parameter int unsigned REG_W    = CPU_REG_W,
    parameter bit          IMM_SEXT = 1'b1,
    localparam int unsigned IMMJ_W  = XLEN - OPC_W,
    localparam int unsigned IMMAB_W = XLEN - OPC_W - 2 * REG_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_data,
    input  logic [XLEN-1:0]    in_pc,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OPC_W-1:0]   opc,
    output logic [REG_W-1:0]   rs1,
    output logic [REG_W-1:0]   rs2_rd,
    output logic [REG_W-1:0]   rd,
    output logic [IMMJ_W-1:0]  imm_j,
    output logic [IMMAB_W-1:0] imm_ab,
    output logic [XLEN-1:0]    imm_ext,
    output logic [XLEN-1:0]    out_pc
);

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [OPC_W-1:0]   opc;
        logic [REG_W-1:0]   rs1;
        logic [REG_W-1:0]   rs2_rd;
        logic [REG_W-1:0]   rd;
        logic [IMMJ_W-1:0]  imm_j;
        logic [IMMAB_W-1:0] imm_ab;
    } fields_t;

    state_e          state_q, state_d;
    logic            in_ready_q, out_valid_q;
    fields_t         main_q, main_d;
    logic [XLEN-1:0] main_ext_q, main_ext_d;
    logic [XLEN-1:0] skid_word_q, skid_word_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;

    fields_t         in_dec, skid_dec;
    logic [XLEN-1:0] in_ext, skid_ext;
    logic            in_xfer, out_xfer;

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;

    // Main can load either the incoming word or the skid word; decode both.
    instr_field_split #(
        .XLEN     (XLEN),
        .OPC_W    (OPC_W),
        .REG_W    (REG_W),
        .IMM_SEXT (IMM_SEXT),
        .dec_t    (fields_t)
    ) u_split_in (
        .word_i    (in_data),
        .pc_i      (in_pc),
        .dec_o     (in_dec),
        .imm_ext_o (in_ext)
    );

    instr_field_split #(
        .XLEN     (XLEN),
        .OPC_W    (OPC_W),
        .REG_W    (REG_W),
        .IMM_SEXT (IMM_SEXT),
        .dec_t    (fields_t)
    ) u_split_skid (
        .word_i    (skid_word_q),
        .pc_i      (skid_pc_q),
        .dec_o     (skid_dec),
        .imm_ext_o (skid_ext)
    );

    // Next-state and storage-load decisions; flush discards everything.
    always_comb begin
        state_d     = state_q;
        main_d      = main_q;
        main_ext_d  = main_ext_q;
        skid_word_d = skid_word_q;
        skid_pc_d   = skid_pc_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d    = ONE;
                        main_d     = in_dec;
                        main_ext_d = in_ext;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_d     = in_dec;
                        main_ext_d = in_ext;
                    end else if (in_xfer) begin
                        state_d     = TWO;
                        skid_word_d = in_data;
                        skid_pc_d   = in_pc;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        state_d    = ONE;
                        main_d     = skid_dec;
                        main_ext_d = skid_ext;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Handshake flags are registered from the next state so they stay glitch-free.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            main_q      <= '0;
            main_ext_q  <= '0;
            skid_word_q <= '0;
            skid_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != TWO);
            out_valid_q <= (state_d != EMPTY);
            main_q      <= main_d;
            main_ext_q  <= main_ext_d;
            skid_word_q <= skid_word_d;
            skid_pc_q   <= skid_pc_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign opc       = main_q.opc;
    assign rs1       = main_q.rs1;
    assign rs2_rd    = main_q.rs2_rd;
    assign rd        = main_q.rd;
    assign imm_j     = main_q.imm_j;
    assign imm_ab    = main_q.imm_ab;
    assign imm_ext   = main_ext_q;
    assign out_pc    = main_q.pc;

endmodule

// File: tb/tb_instr_decode_reg.sv
// Bench for instr_decode_reg: directed scenarios plus random traffic checked
// against a FIFO-queue model; a second instance covers zero-extension.
module tb_instr_decode_reg;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, flush, out_ready;
    logic [31:0] in_data, in_pc;

    logic        in_ready, out_valid;
    logic [5:0]  opc;
    logic [4:0]  rs1, rs2_rd, rd;
    logic [25:0] imm_j;
    logic [15:0] imm_ab;
    logic [31:0] imm_ext, out_pc;

    logic        z_in_ready, z_out_valid;
    logic [5:0]  z_opc;
    logic [4:0]  z_rs1, z_rs2_rd, z_rd;
    logic [25:0] z_imm_j;
    logic [15:0] z_imm_ab;
    logic [31:0] z_imm_ext, z_out_pc;

    int checks = 0;
    int errors = 0;

    logic [63:0] mq[$];
    bit          rdy_m;
    logic [31:0] last_w, last_pc;

    always #5 clk = ~clk;

    instr_decode_reg #(.IMM_SEXT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .opc(opc), .rs1(rs1), .rs2_rd(rs2_rd), .rd(rd),
        .imm_j(imm_j), .imm_ab(imm_ab), .imm_ext(imm_ext), .out_pc(out_pc)
    );

    instr_decode_reg #(.IMM_SEXT(1'b0)) dut_z (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(z_in_ready),
        .in_data(in_data), .in_pc(in_pc), .flush(flush), .out_valid(z_out_valid),
        .out_ready(out_ready), .opc(z_opc), .rs1(z_rs1), .rs2_rd(z_rs2_rd), .rd(z_rd),
        .imm_j(z_imm_j), .imm_ab(z_imm_ab), .imm_ext(z_imm_ext), .out_pc(z_out_pc)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Queue model: the front entry is on the outputs; fields track the last main word.
    task automatic model_update();
        bit ix, ox;
        if (!rst_n) begin
            mq.delete();
            rdy_m   = 1'b0;
            last_w  = '0;
            last_pc = '0;
        end else if (flush) begin
            mq.delete();
            rdy_m = 1'b1;
        end else begin
            ix = in_valid && rdy_m;
            ox = (mq.size() > 0) && out_ready;
            if (ox) void'(mq.pop_front());
            if (ix) mq.push_back({in_data, in_pc});
            rdy_m = (mq.size() < 2);
            if (mq.size() > 0) begin
                last_w  = mq[0][63:32];
                last_pc = mq[0][31:0];
            end
        end
    endtask

    task automatic check_outputs();
        logic [31:0] w, ab, sx;
        w  = last_w;
        ab = w & 32'h0000_FFFF;
        sx = (ab >= 32'h8000) ? (ab + 32'hFFFF_0000) : ab;
        check_eq("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        check_eq("in_ready",  32'(in_ready),  32'(rdy_m));
        check_eq("opc",       32'(opc),       w >> 26);
        check_eq("rs1",       32'(rs1),       (w >> 21) & 32'd31);
        check_eq("rs2_rd",    32'(rs2_rd),    (w >> 16) & 32'd31);
        check_eq("rd",        32'(rd),        ab >> 11);
        check_eq("imm_j",     32'(imm_j),     w & 32'h03FF_FFFF);
        check_eq("imm_ab",    32'(imm_ab),    ab);
        check_eq("imm_ext",   imm_ext,        sx);
        check_eq("out_pc",    out_pc,         last_pc);
        check_eq("z_out_valid", 32'(z_out_valid), 32'(mq.size() > 0));
        check_eq("z_in_ready",  32'(z_in_ready),  32'(rdy_m));
        check_eq("z_regs",   32'({z_opc, z_rs1, z_rs2_rd}), w >> 16);
        check_eq("z_rd",     32'(z_rd),     ab >> 11);
        check_eq("z_imm_j",  32'(z_imm_j),  w & 32'h03FF_FFFF);
        check_eq("z_imm_ab", 32'(z_imm_ab), ab);
        check_eq("z_imm_ext", z_imm_ext,    ab);
        check_eq("z_out_pc",  z_out_pc,     last_pc);
    endtask

    // Drive one cycle from a negedge, update the model at the edge, check at the next negedge.
    task automatic step(input bit r, input bit iv, input logic [31:0] d, input logic [31:0] p,
                        input bit fl, input bit ordy);
        rst_n     = r;
        in_valid  = iv;
        in_data   = d;
        in_pc     = p;
        flush     = fl;
        out_ready = ordy;
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        bit r, iv, fl, ordy;
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_data = '0; in_pc = '0;
        rdy_m = 1'b0; last_w = '0; last_pc = '0;
        @(negedge clk);

        // Reset with in_valid asserted
        repeat (3) step(1'b0, 1'b1, $urandom, $urandom, 1'b0, 1'b1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready",  32'(in_ready),  32'd0);
        check_eq("rst_out_pc",    out_pc,         32'd0);
        check_eq("rst_imm_ext",   imm_ext,        32'd0);
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        check_eq("rel_in_ready",  32'(in_ready),  32'd1);

        // Field split of a known word
        step(1'b1, 1'b1, 32'h8C22_FFFC, 32'h100, 1'b0, 1'b1);
        check_eq("fs_valid",  32'(out_valid), 32'd1);
        check_eq("fs_opc",    32'(opc),       32'h23);
        check_eq("fs_rs1",    32'(rs1),       32'd1);
        check_eq("fs_rs2_rd", 32'(rs2_rd),    32'd2);
        check_eq("fs_rd",     32'(rd),        32'd31);
        check_eq("fs_imm_ab", 32'(imm_ab),    32'hFFFC);
        check_eq("fs_imm_j",  32'(imm_j),     32'h022_FFFC);
        check_eq("fs_sext",   imm_ext,        32'hFFFF_FFFC);
        check_eq("fs_zext",   z_imm_ext,      32'h0000_FFFC);
        check_eq("fs_pc",     out_pc,         32'h100);

        // Streaming A, B, C
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 32'h1000_0000 + 32'(i), 32'h200 + 32'(4 * i), 1'b0, 1'b1);
            check_eq("st_in_ready", 32'(in_ready), 32'd1);
            check_eq("st_pc", out_pc, 32'h200 + 32'(4 * i));
        end
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        check_eq("st_drain", 32'(out_valid), 32'd0);

        // Back-pressure
        step(1'b1, 1'b1, 32'h2000_8001, 32'h300, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h2100_0002, 32'h304, 1'b0, 1'b0);
        check_eq("bp_full_rdy", 32'(in_ready), 32'd0);
        check_eq("bp_hold_a",   out_pc,        32'h300);
        step(1'b1, 1'b1, 32'h2200_F003, 32'h308, 1'b0, 1'b0);
        check_eq("bp_still_a",  out_pc,        32'h300);
        step(1'b1, 1'b1, 32'h2200_F003, 32'h308, 1'b0, 1'b1);
        check_eq("bp_b",        out_pc,        32'h304);
        step(1'b1, 1'b1, 32'h2200_F003, 32'h308, 1'b0, 1'b1);
        check_eq("bp_c",        out_pc,        32'h308);
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);

        // Flush in TWO with a concurrent word D
        step(1'b1, 1'b1, 32'h3000_0001, 32'h400, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h3000_0002, 32'h404, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h3DDD_DDDD, 32'h40C, 1'b1, 1'b0);
        check_eq("fl_valid", 32'(out_valid), 32'd0);
        check_eq("fl_ready", 32'(in_ready),  32'd1);
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        check_eq("fl_no_d",  32'(out_valid), 32'd0);

        // Reset in TWO
        step(1'b1, 1'b1, 32'h4000_0001, 32'h500, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h4000_0002, 32'h504, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h4000_0003, 32'h508, 1'b0, 1'b1);
        check_eq("mr_valid", 32'(out_valid), 32'd0);
        step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        check_eq("mr_stale", 32'(out_valid), 32'd0);
        check_eq("mr_pc",    out_pc,         32'd0);

        // Random traffic, two back-pressure regimes
        for (int i = 0; i < 3000; i++) begin
            r    = ($urandom % 200) != 0;
            fl   = ($urandom % 30) == 0;
            iv   = ($urandom % 4) != 0;
            ordy = (i < 1500) ? (($urandom % 3) != 0) : (($urandom % 3) == 0);
            step(r, iv, $urandom, $urandom, fl, ordy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_decode_reg.md
Name: instr_decode_reg

Overview:
Parametrised successor to the single-stage instruction register: it sits between instruction fetch and decode/register-file read. It captures a fetched instruction word and its PC through a valid/ready handshake, splits the word into fields, and sign- or zero-extends the ALU/branch immediate. A 2-entry skid buffer lets back-pressure from decode stall fetch without bubbles or combinational ready paths. It supports pipeline flush for taken branches and jumps.

Parameters:
XLEN, 32, instruction and PC width
OPC_W, 6, opcode field width (MSBs of the word)
REG_W, 5, register-specifier width
IMM_SEXT, 1, 1 = sign-extend imm_ab to XLEN, 0 = zero-extend
Derived (localparam, not overridable): IMMJ_W = XLEN-OPC_W (26); IMMAB_W = XLEN-OPC_W-2*REG_W (16); require IMMAB_W > REG_W.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  fetch presents a word
in_ready  out  1  block can accept a word this cycle
in_data  in  XLEN  instruction word
in_pc  in  XLEN  PC of in_data
flush  in  1  discard all held and incoming instructions
out_valid  out  1  decoded fields valid
out_ready  in  1  decode accepts the current output
opc  out  OPC_W  in_data[XLEN-1 -: OPC_W]
rs1  out  REG_W  next REG_W bits below opc
rs2_rd  out  REG_W  next REG_W bits below rs1
rd  out  REG_W  top REG_W bits of imm_ab
imm_j  out  IMMJ_W  in_data[IMMJ_W-1:0]
imm_ab  out  IMMAB_W  in_data[IMMAB_W-1:0]
imm_ext  out  XLEN  imm_ab extended per IMM_SEXT
out_pc  out  XLEN  PC of the output instruction

Behaviour:
- Only clk is used. All state resets synchronously while rst_n=0: out_valid=0, in_ready=0 during reset and 1 from the first cycle after release, all field/PC outputs 0, state EMPTY.
- Input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
- Storage is a main register (drives outputs) plus a skid register. Decoded fields are registered alongside the raw word, so outputs are purely registered.
- States:
  - EMPTY: in xfer -> ONE.
  - ONE: in xfer and out xfer -> ONE, main reloads. In xfer only -> TWO, word goes to skid. Out xfer only -> EMPTY.
  - TWO: out xfer -> ONE, skid moves to main. No in xfer is possible.
- in_ready = (state != TWO), decoded from state only. There is no combinational path from out_ready or in_valid to in_ready.
- out_valid = (state != EMPTY).
- Latency: a word accepted in cycle N appears on the outputs in cycle N+1 when main is free. Sustained throughput is 1 per cycle.
- Ordering is strictly FIFO. No word is dropped or duplicated except by flush.
- Output stability: while out_valid=1 and out_ready=0, all outputs hold.
- flush=1: the next state is EMPTY with out_valid=0, and any in xfer in the same cycle is discarded. Flush takes priority over everything except reset. in_ready stays as decoded from state during the flush cycle, so in_ready is 1 in the following cycle.
- Reset mid-operation: held words are lost, with no partial output.
- Field outputs always reflect the bit slices of the main word. Decoding is opcode-agnostic.
- imm_ext sign-extends from bit IMMAB_W-1 when IMM_SEXT=1, otherwise it zero-extends.

Decomposition:
- Shared package cpu_pkg holds XLEN/OPC_W/REG_W defaults, the derived-width localparams, the state enum (EMPTY, ONE, TWO), and a packed struct for decoded fields plus PC.
- One natural sub-module: instr_field_split, purely combinational. It takes the word and returns the struct and imm_ext, and is instantiated once per register input.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0 and all outputs 0. in_ready=0 during reset and 1 in the cycle after release.
- Field split: word 0x8C22FFFC, pc 0x100, out_ready=1 -> next cycle opc=0x23, rs1=1, rs2_rd=2, rd=31, imm_ab=0xFFFC, imm_j=0x022FFFC, out_pc=0x100. imm_ext=0xFFFFFFFC with IMM_SEXT=1, 0x0000FFFC with IMM_SEXT=0.
- Streaming: words A, B, C back-to-back with out_ready=1 -> outputs A, B, C on consecutive cycles, and in_ready stays 1.
- Back-pressure: out_ready=0 while A, B are sent -> in_ready falls after B (state TWO) and outputs hold A. Raising out_ready -> A, then B, then C accepted, in order and with no loss.
- Flush: in state TWO, assert flush together with in_valid for word D -> next cycle out_valid=0 and in_ready=1. D never appears on the outputs.
- Reset mid-stream: in state TWO pull rst_n low for 1 cycle -> EMPTY, out_valid=0, and no stale word after release.
